// File: rtl/data_mem_unit.sv
// RV32 memory-stage data memory: byte/half/word loads and stores, valid/ready request, one-cycle response pulse.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned or illegal-size requests complete with err=1 instead of being aligned down.
module data_mem_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWr,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;
  logic [3:0] cnt;
  logic accept, enter_resp;

  logic          cap_wr, cap_rd;
  logic [2:0]    cap_f3;
  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_wdata;

  logic          cur_wr, cur_rd;
  logic [2:0]    cur_f3;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;

  logic          size_byte, size_half, size_word, fault;
  logic [1:0]    off, eff_off;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   lane, rdata_word, shifted, load_val;

  logic [31:0] mem [DEPTH];
  logic unused_addr;

  assign unused_addr = ^addr[31:AW+2];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, RESP: begin
        if (req_valid) next_state = (LATENCY == 1) ? RESP : WAIT;
        else           next_state = IDLE;
      end
      WAIT:    if (cnt == 4'd1) next_state = RESP;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    case (state)
      WAIT:    req_ready = 1'b0;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign enter_resp = (next_state == RESP);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt       <= 4'd0;
      cap_wr    <= 1'b0;
      cap_rd    <= 1'b0;
      cap_f3    <= 3'd0;
      cap_addr  <= '0;
      cap_wdata <= 32'd0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      cap_wr    <= MemWr;
      cap_rd    <= MemRead;
      cap_f3    <= funct3;
      cap_addr  <= addr[AW+1:0];
      cap_wdata <= write_data;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With LATENCY=1 the access completes on the accept edge, so use the live inputs; otherwise the captured ones.
  always_comb begin
    if (state == WAIT) begin
      cur_wr    = cap_wr;
      cur_rd    = cap_rd;
      cur_f3    = cap_f3;
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
    end else begin
      cur_wr    = MemWr;
      cur_rd    = MemRead;
      cur_f3    = funct3;
      cur_addr  = addr[AW+1:0];
      cur_wdata = write_data;
    end
  end

  assign size_byte = (cur_f3[1:0] == 2'b00);
  assign size_half = (cur_f3[1:0] == 2'b01);
  assign size_word = !size_byte && !size_half;
  assign off       = cur_addr[1:0];
  assign idx       = cur_addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault   = (cur_wr || cur_rd) &&
                   ((size_half && off[0]) || (size_word && (off != 2'b00)) ||
                    (cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11));
  assign eff_off = off;
`else
  assign fault   = 1'b0;
  assign eff_off = size_word ? 2'b00 : (size_half ? {off[1], 1'b0} : off);
`endif

  always_comb begin
    be   = 4'b1111;
    lane = cur_wdata;
    if (size_byte) begin
      be   = 4'b0001 << eff_off;
      lane = {4{cur_wdata[7:0]}};
    end else if (size_half) begin
      be   = eff_off[1] ? 4'b1100 : 4'b0011;
      lane = {2{cur_wdata[15:0]}};
    end
  end

  assign rdata_word = mem[idx];
  assign shifted    = rdata_word >> {eff_off, 3'b000};

  always_comb begin
    load_val = rdata_word;
    if (size_byte)
      load_val = cur_f3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (size_half)
      load_val = cur_f3[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  // Array is deliberately unreset; gating on n_rst keeps a held request from writing during reset.
  always_ff @(posedge clk) begin
    if (n_rst && enter_resp && cur_wr && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      read_data <= 32'd0;
    end else if (enter_resp) begin
      read_data <= (cur_rd && !cur_wr && !fault) ? load_val : 32'd0;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)          err <= 1'b0;
    else if (enter_resp) err <= fault;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data memory for the RV32 memory stage: a word-organised array with byte/halfword/word loads and stores (funct3-encoded), sign/zero extension, a configurable access latency and a valid/ready request handshake with a one-cycle response pulse. It sits between the execute/memory pipeline register and writeback. It supports stalling the pipeline on `req_ready`, which lets a slower memory be modelled without touching the core.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 1: cycles from request acceptance to response; legal range 1..8.

- `clk`  in  1  clock, all state on rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `MemWr`  in  1  store request.
- `MemRead`  in  1  load request.
- `funct3`  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  32  byte address.
- `write_data`  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `read_data`  out  32  extended load result; held until next response.
- `err`  out  1  access fault, qualified by `resp_valid`; constant 0 without the macro.

## Operation
- Word index = `addr[log2(DEPTH)+1:2]`; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- The array is not reset; its contents are undefined until written.
- Acceptance: `req_valid && req_ready` at a rising edge. Request fields are captured at that edge. Inputs are don't-care afterwards.
- FSM states:
  - IDLE: `req_ready`=1. On accept, load counter with LATENCY-1 and go to WAIT, or to RESP directly if LATENCY=1.
  - WAIT: `req_ready`=0. Counter decrements each cycle. At 0, go to RESP.
  - RESP: `resp_valid`=1, `req_ready`=1. The store commits on entry to RESP. A new request accepted here goes to WAIT or RESP exactly as from IDLE. Otherwise go to IDLE.
- Store byte enables:
  - SB: byte `addr[1:0]`.
  - SH: half `addr[1]`.
  - SW: all four bytes.
  - Bytes not enabled are unchanged.
- Load extraction:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: full word.
  - The array is read at the end of WAIT/accept, so `read_data` reflects all earlier committed stores.
- Stores return `read_data`=0.
- MemWr and MemRead both set: treated as a store.
- Neither set: accepted as a no-op. It still produces `resp_valid`, with `read_data`=0 and no write.
- Without the macro, funct3 011/110/111 is treated as 010 (word).

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `read_data`=0, `err`=0. The FSM is in IDLE and the counter is 0.
- Request accepted at edge N: `resp_valid` is high in the cycle after edge N+LATENCY-1, and a store is visible to a load accepted at or after that edge.
- Back-to-back throughput: one request per LATENCY cycles.
- Reset asserted mid-operation: the FSM returns to IDLE and the captured request is discarded. A pending store is not committed. The array keeps its committed contents.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: faulting requests complete with `err`=1 and `read_data`=0, and no array write occurs. A request faults if it is:
  - a halfword access with `addr[0]`=1;
  - a word access with `addr[1:0]`≠0;
  - a funct3 of 011/110/111.
- `DMEM_MISALIGN_TRAP_EN` not defined:
  - `err` is tied to 0;
  - misaligned addresses are aligned down to the access size (`addr[0]` cleared for halfwords, `addr[1:0]` cleared for words);
  - illegal funct3 is treated as a word access.

## Test plan
- Reset then write/read, LATENCY=1: SW 0xDEADBEEF to 0x10, then LW 0x10 → `read_data`=0xDEADBEEF one cycle after acceptance, `resp_valid` pulses once.
- Byte/half extension: SB 0x80 to 0x21, LB 0x21 → 0xFFFFFF80; LBU 0x21 → 0x00000080; SH 0x8001 to 0x22, LH 0x22 → 0xFFFF8001.
- LATENCY=4, back-to-back: accept at edge 0, hold `req_valid` → `req_ready`=0 for 3 cycles, `resp_valid` in cycle 4, second request accepted at edge 4.
- Wrap, DEPTH=256: SW 0x12345678 to 0x400, LW 0x000 → 0x12345678.
- Misaligned LW at 0x13:
  - with macro → `err`=1, `read_data`=0;
  - without macro → returns the word at 0x10.
  - In both cases an SW at 0x13 writes nothing with the macro.
- Reset during WAIT of an SW to 0x30 → later LW 0x30 returns the prior contents; `resp_valid` and `read_data` are 0 immediately on reset.
